// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared constants for the switch debouncer slice.
//   DEFAULT_SYNC_STAGES  : default synchronizer depth per channel
//   DEFAULT_STABLE_COUNT : default number of enabled mismatch samples to accept
//   cnt_width_for()      : smallest counter width able to hold STABLE_COUNT-1
// -----------------------------------------------------------------------------
package switch_pkg;

    localparam int DEFAULT_SYNC_STAGES  = 2;
    localparam int DEFAULT_STABLE_COUNT = 50000;

    // The counter tops out at stable_count-1, so it needs
    // 2^width >= stable_count, with at least one bit.
    function automatic int cnt_width_for(input int stable_count);
        return (stable_count <= 2) ? 1 : $clog2(stable_count);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One switch channel: synchronizer chain, stability counter, debounced level
// and registered one-cycle rise/fall pulses.
// Ports:
//   clock     : system clock, rising edge
//   nreset    : asynchronous active-low reset
//   sample_en : debounce sample strobe (counter advances only when high)
//   raw       : asynchronous switch pin
//   level     : debounced level
//   rise      : one-cycle pulse on accepted 0->1
//   fall      : one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module debounce_channel
    import switch_pkg::*;
#(
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic clock,
    input  logic nreset,
    input  logic sample_en,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic [CNT_WIDTH-1:0]   count_reg, count_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    // Free-running synchronizer; deliberately not gated by sample_en so the
    // metastability window is independent of the prescaler rate.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    always_comb begin
        count_next = count_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (sync_out == level_reg) begin
            // Agreement at any time (even unsampled) restarts the count,
            // so a single bounce back discards all progress.
            count_next = '0;
        end else if (sample_en) begin
            if (count_reg == TERMINAL) begin
                level_next = sync_out;
                count_next = '0;
                rise_next  = sync_out;
                fall_next  = ~sync_out;
            end else begin
                count_next = count_reg + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            count_reg <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Multi-channel switch/button debouncer; CHANNELS independent debounce_channel
// instances plus a combined change flag.
// Ports:
//   clock     : system clock, rising edge
//   nreset    : asynchronous active-low reset
//   sample_en : debounce sample strobe shared by all channels
//   raw       : [CHANNELS] asynchronous switch pins
//   level     : [CHANNELS] debounced levels
//   rise      : [CHANNELS] one-cycle pulses on accepted 0->1
//   fall      : [CHANNELS] one-cycle pulses on accepted 1->0
//   changed   : high whenever any rise or fall pulse is high
// -----------------------------------------------------------------------------
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int CHANNELS     = 8,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    // Refuse to build a counter that cannot reach STABLE_COUNT-1.
    if (CNT_WIDTH < cnt_width_for(STABLE_COUNT)) begin : g_bad_cnt_width
        $error("switch_debouncer: CNT_WIDTH too small for STABLE_COUNT");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_COUNT (STABLE_COUNT),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_channel (
            .clock     (clock),
            .nreset    (nreset),
            .sample_en (sample_en),
            .raw       (raw[gi]),
            .level     (level[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
        );
    end

    // Built from registered pulses, so it is glitch-free and aligned with them.
    assign changed = |(rise | fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed bench for switch_debouncer with CHANNELS=4, SYNC_STAGES=2,
// STABLE_COUNT=4. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    logic       clock = 1'b0;
    logic       nreset = 1'b1;
    logic       sample_en = 1'b1;
    logic [3:0] raw = 4'h0;
    logic [3:0] level, rise, fall;
    logic       changed;

    int tests_run = 0;
    int tests_failed = 0;

    switch_debouncer #(
        .CHANNELS     (4),
        .SYNC_STAGES  (2),
        .STABLE_COUNT (4),
        .CNT_WIDTH    (2)
    ) dut (
        .clock     (clock),
        .nreset    (nreset),
        .sample_en (sample_en),
        .raw       (raw),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        tests_run++;
        assert (observed === expected)
            $display("[TB] %s ok: observed=%h", tag, observed);
        else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // 1. Asynchronous reset mid-cycle with all pins high.
        raw = 4'hF;
        tick(2);
        #2 nreset = 1'b0;
        #1;
        check("rst_level", level, 4'h0);
        check("rst_rise", rise, 4'h0);
        check("rst_fall", fall, 4'h0);
        check("rst_changed", {3'b0, changed}, 4'h0);
        raw = 4'h0;
        tick(3);
        nreset = 1'b1;
        tick(8);
        check("idle_level", level, 4'h0);

        // 2. Clean press on channel 0: raw set before edge 1, level at edge 6.
        raw[0] = 1'b1;
        tick(5);
        check("press_e5_level", level, 4'h0);
        tick(1);
        check("press_e6_level", level, 4'h1);
        check("press_e6_rise", rise, 4'h1);
        check("press_e6_fall", fall, 4'h0);
        check("press_e6_changed", {3'b0, changed}, 4'h1);
        tick(1);
        check("press_e7_rise", rise, 4'h0);
        check("press_e7_changed", {3'b0, changed}, 4'h0);

        // 3. Bounce on channel 1: high 3 edges, low 1 edge, then high.
        raw[1] = 1'b1;
        tick(3);
        raw[1] = 1'b0;
        tick(1);
        raw[1] = 1'b1;            // final high lands before local edge 5
        tick(2);
        check("bounce_e6_level", level, 4'h1);
        tick(3);
        check("bounce_e9_level", level, 4'h1);
        tick(1);
        check("bounce_e10_level", level, 4'h3);
        check("bounce_e10_rise", rise, 4'h2);
        tick(1);
        check("bounce_e11_rise", rise, 4'h0);

        // 4. Gated sampling on channel 2: sample_en 1 on odd edges, 0 on even.
        raw[2] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            sample_en = (j % 2 == 1);
            tick(1);
        end
        check("gate_e8_level", level, 4'h3);
        sample_en = 1'b1;
        tick(1);
        check("gate_e9_level", level, 4'h7);
        check("gate_e9_rise", rise, 4'h4);
        tick(1);
        check("gate_e10_rise", rise, 4'h0);

        // 5. Simultaneous fall on channel 2 and rise on channel 3.
        raw[2] = 1'b0;
        raw[3] = 1'b1;
        tick(5);
        check("simul_e5_changed", {3'b0, changed}, 4'h0);
        tick(1);
        check("simul_e6_level", level, 4'hB);
        check("simul_e6_rise", rise, 4'h8);
        check("simul_e6_fall", fall, 4'h4);
        check("simul_e6_changed", {3'b0, changed}, 4'h1);
        tick(1);
        check("simul_e7_changed", {3'b0, changed}, 4'h0);

        // 6. Reset mid-debounce on channel 0. First bring it back to 0.
        raw[0] = 1'b0;
        tick(6);
        check("release0_fall", fall, 4'h1);
        check("release0_level", level, 4'hA);
        raw[0] = 1'b1;
        tick(4);                  // two mismatch edges counted (edges 3, 4)
        check("mid_level", level, 4'hA);
        nreset = 1'b0;
        #2;
        check("mid_rst_level", level, 4'h0);
        tick(1);
        nreset = 1'b1;            // release before edge 1; all held-high pins re-debounce
        tick(5);
        check("post_rst_e5_level", level, 4'h0);
        tick(1);
        check("post_rst_e6_level", level, 4'hB);
        check("post_rst_e6_rise", rise, 4'hB);
        tick(1);
        check("post_rst_e7_rise", rise, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
